// File: rtl/interp_pkg.sv
// Shared types for the linear interpolator: controller state encoding.
package interp_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PRIMED = 2'd1,
    RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/interp_lin.sv
// Linear interpolator: emits 2^N evenly spaced samples per input interval prev->cur.
// Latency: first output of an interval is visible the cycle after the second sample is accepted.
// Backpressure: o_rdy low freezes output, counter and accumulator; i_rdy in RUN only opens on the last beat.
module interp_lin
  import interp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [WIDTH-1:0] o_data
);

  localparam int DW = WIDTH + 1;
  localparam int AW = WIDTH + N + 1;
  localparam logic [N-1:0] KMAX = '1;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] cur;
  logic [DW-1:0]    delta;
  logic [AW-1:0]    acc;
  logic [N-1:0]     k;

  logic [AW-1:0] acc_inc;
  logic [DW-1:0] delta_prime;
  logic [DW-1:0] delta_run;
  logic          last_beat;

  // acc holds prev*2^N + delta*k, so its upper bits are the floored sample
  assign acc_inc     = acc + {{N{delta[DW-1]}}, delta};
  assign delta_prime = {i_data[WIDTH-1], i_data} - {prev[WIDTH-1], prev};
  assign delta_run   = {i_data[WIDTH-1], i_data} - {cur[WIDTH-1], cur};
  assign last_beat   = (state == RUN) && o_rdy && (k == KMAX);

  assign i_rdy = rstn && !i_clr &&
                 ((state == EMPTY) || (state == PRIMED) || last_beat);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= EMPTY;
      o_vld  <= 1'b0;
      o_data <= '0;
      k      <= '0;
      acc    <= '0;
      prev   <= '0;
      cur    <= '0;
      delta  <= '0;
    end else if (i_clr) begin
      state <= EMPTY;
      o_vld <= 1'b0;
      k     <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (i_vld) begin
            prev  <= i_data;
            state <= PRIMED;
          end
        end
        PRIMED: begin
          if (i_vld) begin
            cur    <= i_data;
            delta  <= delta_prime;
            acc    <= {prev[WIDTH-1], prev, {N{1'b0}}};
            k      <= '0;
            o_vld  <= 1'b1;
            o_data <= prev;
            state  <= RUN;
          end
        end
        RUN: begin
          if (last_beat) begin
            prev <= cur;
            k    <= '0;
            if (i_vld) begin
              // back-to-back interval: cur becomes the next first sample, no bubble
              cur    <= i_data;
              delta  <= delta_run;
              acc    <= {cur[WIDTH-1], cur, {N{1'b0}}};
              o_data <= cur;
            end else begin
              o_vld <= 1'b0;
              state <= PRIMED;
            end
          end else if (o_rdy) begin
            acc    <= acc_inc;
            k      <= k + 1'b1;
            o_data <= acc_inc[WIDTH+N-1:N];
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/interp_lin.md
INTERP_LIN -- requirements
Module: interp_lin

Interface
REQ-001 SHALL have parameter WIDTH, default 32: signed two's-complement sample width.
REQ-002 SHALL have parameter N, default 1: log2 of interpolation factor; 2^N output samples per input interval; N>=1.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rstn  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_clr  input  1: synchronous clear to EMPTY, no output.
REQ-006 SHALL have port i_vld  input  1: input sample valid.
REQ-007 SHALL have port i_rdy  output  1: input sample accepted when i_vld && i_rdy.
REQ-008 SHALL have port i_data  input  WIDTH: signed input sample.
REQ-009 SHALL have port o_vld  output  1: output sample valid, registered.
REQ-010 SHALL have port o_rdy  input  1: downstream accepts when o_vld && o_rdy.
REQ-011 SHALL have port o_data  output  WIDTH: signed interpolated sample, registered.

Function
REQ-012 SHALL implement states EMPTY (no sample held), PRIMED (prev held), RUN (emitting interval prev->cur).
REQ-013 EMPTY: i_rdy=1; on accept, prev<=i_data, go PRIMED; no output.
REQ-014 PRIMED: i_rdy=1; on accept, cur<=i_data, delta<=cur-prev at WIDTH+1 bits signed, acc<=prev<<N, k<=0, go RUN.
REQ-015 RUN: o_vld=1; o_data=acc>>>N (arithmetic) truncated to WIDTH, i.e. prev+floor(delta*k/2^N); on each output handshake acc<=acc+delta, k<=k+1.
REQ-016 acc SHALL be WIDTH+N+1 bits signed; no saturation needed (result always lies between prev and cur).
REQ-017 i_rdy in RUN SHALL be 1 only when k==2^N-1 && o_rdy (combinational o_rdy->i_rdy path permitted).
REQ-018 Last handshake (k==2^N-1) with simultaneous input accept: prev<=cur, cur<=i_data, delta recomputed, acc<=cur<<N, k<=0, stay RUN; no bubble on o_vld.
REQ-019 Last handshake without input accept: prev<=cur, go PRIMED, o_vld<=0 next cycle.
REQ-020 o_vld && !o_rdy: o_data, k, acc, state SHALL hold unchanged.
REQ-021 Latency: accept in PRIMED at edge t -> o_vld=1, o_data=prev after edge t+1 (first output visible in the cycle following acceptance).
REQ-022 i_clr SHALL take priority over all handshakes: next state EMPTY, o_vld=0; i_rdy=0 in the i_clr cycle.
REQ-023 First output of each interval SHALL equal prev exactly; the last is prev+floor(delta*(2^N-1)/2^N); cur is emitted exactly as the first sample of the following interval.
REQ-024 k SHALL be N bits and wrap 2^N-1 -> 0 only via REQ-018/019.

Reset
REQ-025 rstn low SHALL asynchronously force state EMPTY, o_vld=0, o_data=0, k=0, acc=0, prev=0, cur=0, delta=0.
REQ-026 Reset mid-RUN SHALL discard the interval; after release the first accepted sample only primes (no output).
REQ-027 i_rdy SHALL be 0 while rstn is low.

Structure
REQ-028 State enum (EMPTY, PRIMED, RUN) SHALL reside in shared package interp_pkg.
REQ-029 Block SHALL be a single module with no sub-modules; widths derived from WIDTH and N via localparams.

Verification
REQ-030 WIDTH=16,N=2: samples 0 then 8, o_rdy=1 -> o_data 0,2,4,6, then o_vld=0, state PRIMED.
REQ-031 Continue with 4 offered during last beat -> no bubble; outputs 8,7,6,5.
REQ-032 Samples 0 then -3 -> outputs 0,-1,-2,-3 (arithmetic shift floor).
REQ-033 Samples 100 then 200, o_rdy low 3 cycles at k=1 -> o_data held at 125, o_vld held 1, i_rdy=0; resumes 150,175.
REQ-034 rstn asserted mid-RUN at k=2 -> o_vld=0 immediately; after release samples 5,9 -> outputs 5,6,7,8.
REQ-035 i_clr pulsed in PRIMED with i_vld=1 -> no accept, state EMPTY; next sample primes only.
